// File: rtl/pll_cmp_pkg.sv
// pll_cmp_pkg
// Shared definitions for the PLL frequency comparator:
//   - AdjustFreq codes (speed up / slow down / no change)
//   - comparator FSM state encoding
//   - adj_decide(): maps an accumulated window error onto an AdjustFreq code
`timescale 1ns/1ps
package pll_cmp_pkg;

  localparam logic [1:0] ADJ_UP   = 2'b11;
  localparam logic [1:0] ADJ_DOWN = 2'b00;
  localparam logic [1:0] ADJ_HOLD = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMING = 2'd1,
    ST_RUN    = 2'd2
  } cmp_state_t;

  // Negative error means too few PLL edges, so the VFO must speed up.
  function automatic logic [1:0] adj_decide(input int acc, input int thresh);
    if (acc < -thresh) begin
      return ADJ_UP;
    end else if (acc > thresh) begin
      return ADJ_DOWN;
    end
    return ADJ_HOLD;
  endfunction

endpackage

// File: rtl/pll_freq_comparator_if.sv
// pll_freq_comparator_if
// Groups the comparator's control and result signals.
//   Enable        run enable (driven by the controller side)
//   RefIn         reference clock, sampled as data
//   PllIn         PLL/VFO output, sampled as data
//   AdjustFreq    2-bit frequency adjust code
//   DecisionValid one-cycle strobe when AdjustFreq/AvgError update
//   AvgError      signed accumulated error of the last window
//   Locked        lock indication
// master: controller/stimulus side; slave: the comparator.
`timescale 1ns/1ps
interface pll_freq_comparator_if #(
  parameter int CNT_W    = 4,
  parameter int AVG_LOG2 = 3
);
  logic                              Enable;
  logic                              RefIn;
  logic                              PllIn;
  logic [1:0]                        AdjustFreq;
  logic                              DecisionValid;
  logic signed [CNT_W+AVG_LOG2:0]    AvgError;
  logic                              Locked;

  modport master (
    output Enable, RefIn, PllIn,
    input  AdjustFreq, DecisionValid, AvgError, Locked
  );

  modport slave (
    input  Enable, RefIn, PllIn,
    output AdjustFreq, DecisionValid, AvgError, Locked
  );
endinterface

// File: rtl/pll_freq_comparator_edge_sync.sv
// edge_sync
// Two-flop synchronizer for an asynchronous input followed by a registered
// rising-edge detector. The pulse appears 3 clk cycles after the pin rises.
//   clk    sampling clock
//   rst_n  asynchronous active-low reset
//   din    asynchronous input
//   pulse  one-cycle pulse per rising edge of din
`timescale 1ns/1ps
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);
  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s1    <= din;
      s2    <= s1;
      s3    <= s2;
      pulse <= s2 & ~s3;
    end
  end
endmodule

// File: rtl/pll_freq_comparator.sv
// pll_freq_comparator
// Counts PLL rising edges per reference period, accumulates the signed error
// against MULT over 2^AVG_LOG2 periods and issues an AdjustFreq decision.
// Ports:
//   ClockIn  fast sampling clock (>= 4x the faster of RefIn/PllIn)
//   ResetN   asynchronous active-low reset
//   bus      pll_freq_comparator_if.slave (Enable, RefIn, PllIn in;
//            AdjustFreq, DecisionValid, AvgError, Locked out)
// Build option: define PLLCMP_LOCK_DET_EN to build the lock detector;
// otherwise Locked is tied low.
//
// state     | meaning
// ST_IDLE   | Enable low, all counters held clear
// ST_ARMING | enabled, waiting for the first RefEdge to start a clean period
// ST_RUN    | counting PLL edges and accumulating per-period error
`timescale 1ns/1ps
module pll_freq_comparator
  import pll_cmp_pkg::*;
#(
  parameter int MULT     = 1,
  parameter int CNT_W    = 4,
  parameter int AVG_LOG2 = 3,
  parameter int THRESH   = 1,
  parameter int LOCK_CNT = 4
) (
  input  logic                  ClockIn,
  input  logic                  ResetN,
  pll_freq_comparator_if.slave  bus
);
  localparam int ACC_W = CNT_W + AVG_LOG2 + 1;
  localparam int E_W   = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic ref_edge, pll_edge;

  cmp_state_t state, state_nxt;
  logic       arm_start, run_edge, decide;

  logic [CNT_W-1:0]        pll_cnt;
  logic [AVG_LOG2-1:0]     per;
  logic signed [ACC_W-1:0] acc;
  logic signed [E_W-1:0]   err;
  logic signed [ACC_W-1:0] acc_sum;
  int                      acc_int;
  logic                    window_end;
  logic [1:0]              adj_dec;

  logic [1:0]              adj_q;
  logic                    dv_q;
  logic signed [ACC_W-1:0] avg_q;

  edge_sync u_ref_sync (
    .clk   (ClockIn),
    .rst_n (ResetN),
    .din   (bus.RefIn),
    .pulse (ref_edge)
  );

  edge_sync u_pll_sync (
    .clk   (ClockIn),
    .rst_n (ResetN),
    .din   (bus.PllIn),
    .pulse (pll_edge)
  );

  always_ff @(posedge ClockIn or negedge ResetN) begin
    if (!ResetN) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    arm_start = 1'b0;
    run_edge  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.Enable) state_nxt = ST_ARMING;
      end
      ST_ARMING: begin
        if (ref_edge) begin
          state_nxt = ST_RUN;
          arm_start = 1'b1;
        end
      end
      ST_RUN: begin
        if (ref_edge) run_edge = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (!bus.Enable) begin
      state_nxt = ST_IDLE;
      arm_start = 1'b0;
      run_edge  = 1'b0;
    end
  end

  // Error for the period that the current RefEdge closes; the accumulator
  // is wide enough for 2^AVG_LOG2 worst-case errors.
  always_comb begin
    err        = $signed({1'b0, pll_cnt}) - E_W'(MULT);
    acc_sum    = acc + ACC_W'(err);
    acc_int    = 32'(acc_sum);
    window_end = &per;
    decide     = run_edge & window_end;
    adj_dec    = adj_decide(acc_int, THRESH);
  end

  always_ff @(posedge ClockIn or negedge ResetN) begin
    if (!ResetN) begin
      pll_cnt <= '0;
      per     <= '0;
      acc     <= '0;
      adj_q   <= ADJ_HOLD;
      dv_q    <= 1'b0;
      avg_q   <= '0;
    end else if (!bus.Enable) begin
      pll_cnt <= '0;
      per     <= '0;
      acc     <= '0;
      adj_q   <= ADJ_HOLD;
      dv_q    <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      if (arm_start) begin
        // A PLL edge coincident with the arming RefEdge opens the first period.
        pll_cnt <= CNT_W'(pll_edge);
        per     <= '0;
        acc     <= '0;
      end else if (run_edge) begin
        pll_cnt <= CNT_W'(pll_edge);
        per     <= per + 1'b1;
        if (decide) begin
          acc   <= '0;
          avg_q <= acc_sum;
          adj_q <= adj_dec;
          dv_q  <= 1'b1;
        end else begin
          acc <= acc_sum;
        end
      end else if (state == ST_RUN && pll_edge && pll_cnt != CNT_MAX) begin
        pll_cnt <= pll_cnt + 1'b1;
      end
    end
  end

  assign bus.AdjustFreq    = adj_q;
  assign bus.DecisionValid = dv_q;
  assign bus.AvgError      = avg_q;

`ifdef PLLCMP_LOCK_DET_EN
  localparam int LCK_W = $clog2(LOCK_CNT + 1);
  localparam logic [LCK_W-1:0] LOCK_TGT = LCK_W'(LOCK_CNT);

  logic [LCK_W-1:0] lock_cnt;

  always_ff @(posedge ClockIn or negedge ResetN) begin
    if (!ResetN) begin
      lock_cnt <= '0;
    end else if (!bus.Enable) begin
      lock_cnt <= '0;
    end else if (decide) begin
      if (adj_dec == ADJ_HOLD) begin
        if (lock_cnt != LOCK_TGT) lock_cnt <= lock_cnt + 1'b1;
      end else begin
        lock_cnt <= '0;
      end
    end
  end

  // Counter and DecisionValid share a clock edge, so Locked moves with it.
  assign bus.Locked = (lock_cnt == LOCK_TGT);
`else
  // No lock detector in this build; LOCK_CNT only has meaning with it.
  assign bus.Locked = 1'b0 && (LOCK_CNT > 0);
`endif

endmodule

// File: tb/tb_pll_freq_comparator.sv
`timescale 1ns/1ps
module tb_pll_freq_comparator;
  import pll_cmp_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic en1 = 1'b0, en3 = 1'b0;
  logic ref_in = 1'b0, pll_in = 1'b0;

  pll_freq_comparator_if #(.CNT_W(4), .AVG_LOG2(3)) bus1 ();
  pll_freq_comparator_if #(.CNT_W(4), .AVG_LOG2(3)) bus3 ();

  assign bus1.Enable = en1;
  assign bus1.RefIn  = ref_in;
  assign bus1.PllIn  = pll_in;
  assign bus3.Enable = en3;
  assign bus3.RefIn  = ref_in;
  assign bus3.PllIn  = pll_in;

  pll_freq_comparator #(.MULT(1)) dut1 (.ClockIn(clk), .ResetN(rst_n), .bus(bus1));
  pll_freq_comparator #(.MULT(3)) dut3 (.ClockIn(clk), .ResetN(rst_n), .bus(bus3));

  typedef struct {
    logic [1:0] adj;
    int         avg;
    logic       lk;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  exp_t sb_e;
  int   total = 0;
  int   bad = 0;
  int   lc1 = 0, lc3 = 0;
  int   t = 0;
  int   ref_rises = 0;
  int   pat = 0, pat_next = 0;
  int   dv_ref1 = 0;

  // PLL waveform patterns, in ClockIn ticks; a RefIn period is 32 ticks
  // rising at tick offset 0.
  function automatic logic pll_level(input int p, input int tt);
    int m;
    m = tt % 32;
    case (p)
      1: return m < 16;                          // same edge as ref
      2: return ((tt + 31) % 32) < 16;           // ref rate, 1 tick later
      3: return ((tt + 59) % 64) < 32;           // half rate (640 ns)
      4: return ((tt + 11) % 16) < 8;            // double rate (160 ns)
      5: return (m >= 3 && m < 8) || (m >= 14 && m < 19) || (m >= 25 && m < 30);
      6: return (m >= 1 && m < 3) || (m >= 6 && m < 8) || (m >= 11 && m < 13) ||
                (m >= 17 && m < 19) || (m >= 22 && m < 24) || (m >= 27 && m < 29);
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #2;
      t++;
      if (t % 32 == 0) begin
        pat = pat_next;
        ref_rises++;
      end
      ref_in = (t % 32) < 16;
      pll_in = pll_level(pat, t);
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic push(input int inst, input logic [1:0] adj, input int avg);
    exp_t e;
    int   lc;
    lc = (inst == 1) ? lc1 : lc3;
    if (adj == ADJ_HOLD) begin
      if (lc < 4) lc++;
    end else begin
      lc = 0;
    end
    e.adj = adj;
    e.avg = avg;
`ifdef PLLCMP_LOCK_DET_EN
    e.lk = (lc == 4);
`else
    e.lk = 1'b0;
`endif
    if (inst == 1) begin
      lc1 = lc;
      q1.push_back(e);
    end else begin
      lc3 = lc;
      q3.push_back(e);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((q1.size() != 0 || q3.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (q1.size() != 0 || q3.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d pending decisions want 0", name, q1.size() + q3.size());
      q1.delete();
      q3.delete();
    end
  endtask

  // Disable, switch the PLL pattern at a ref-period boundary, re-enable.
  task automatic restart(input int inst, input int p);
    @(posedge clk);
    en1 = 1'b0;
    en3 = 1'b0;
    lc1 = 0;
    lc3 = 0;
    pat_next = p;
    repeat (40) @(posedge clk);
    if (inst == 1) en1 = 1'b1;
    else           en3 = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    cmp({tag, "_adj"},   int'(bus1.AdjustFreq), int'(ADJ_HOLD));
    cmp({tag, "_dv"},    int'(bus1.DecisionValid), 0);
    cmp({tag, "_avg"},   int'(bus1.AvgError), 0);
    cmp({tag, "_lock"},  int'(bus1.Locked), 0);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (bus1.DecisionValid) begin
          dv_ref1 = ref_rises;
          if (q1.size() == 0) begin
            total++;
            bad++;
            $display("FAIL dut1_unexpected_dv: got adj=%0d avg=%0d want no decision",
                     bus1.AdjustFreq, bus1.AvgError);
          end else begin
            sb_e = q1.pop_front();
            cmp("dut1_adj",  int'(bus1.AdjustFreq), int'(sb_e.adj));
            cmp("dut1_avg",  int'(bus1.AvgError), sb_e.avg);
            cmp("dut1_lock", int'(bus1.Locked), int'(sb_e.lk));
          end
        end
        if (bus3.DecisionValid) begin
          if (q3.size() == 0) begin
            total++;
            bad++;
            $display("FAIL dut3_unexpected_dv: got adj=%0d avg=%0d want no decision",
                     bus3.AdjustFreq, bus3.AvgError);
          end else begin
            sb_e = q3.pop_front();
            cmp("dut3_adj",  int'(bus3.AdjustFreq), int'(sb_e.adj));
            cmp("dut3_avg",  int'(bus3.AvgError), sb_e.avg);
            cmp("dut3_lock", int'(bus3.Locked), int'(sb_e.lk));
          end
        end
      end
    join_none

    // Reset values
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    cmp("reset_dut3_adj", int'(bus3.AdjustFreq), int'(ADJ_HOLD));
    cmp("reset_dut3_avg", int'(bus3.AvgError), 0);
    rst_n = 1'b1;

    // PLL edge coincident with ref edge, MULT=1: e=0 every period.
    push(1, ADJ_HOLD, 0);
    push(1, ADJ_HOLD, 0);
    restart(1, 1);
    wait_drain("coincident", 1500);

    // Same rate, PLL edge one tick after ref: same window sum.
    push(1, ADJ_HOLD, 0);
    restart(1, 2);
    wait_drain("offset", 1000);

    // PLL at half rate: counts alternate 1,0 -> sum -4.
    push(1, ADJ_UP, -4);
    restart(1, 3);
    wait_drain("half_rate", 1000);

    // PLL at double rate: +1 per period -> sum +8.
    push(1, ADJ_DOWN, 8);
    restart(1, 4);
    wait_drain("double_rate", 1000);

    // Enable low: AdjustFreq forced to hold, AvgError keeps last value.
    @(posedge clk);
    en1 = 1'b0;
    lc1 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp("disable_adj",  int'(bus1.AdjustFreq), int'(ADJ_HOLD));
    cmp("disable_avg",  int'(bus1.AvgError), 8);
    cmp("disable_lock", int'(bus1.Locked), 0);

    // Re-enable, then reset in the middle of the following window.
    push(1, ADJ_DOWN, 8);
    @(posedge clk);
    en1 = 1'b1;
    wait_drain("reenable", 1000);
    begin
      int r;
      int n;
      r = ref_rises;
      n = 0;
      while ((ref_rises < r + 4 || (t % 32) != 18) && n < 400) begin
        @(posedge clk);
        n++;
      end
      cmp("reset_point_reached", int'(n < 400), 1);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    lc1 = 0;
    begin
      int r0;
      r0 = ref_rises;
      push(1, ADJ_DOWN, 8);
      wait_drain("after_reset", 1000);
      cmp("after_reset_ref_edges", dv_ref1 - r0, 9);
    end

    // MULT=3 with 3 PLL edges per period: four in-band windows.
    push(3, ADJ_HOLD, 0);
    push(3, ADJ_HOLD, 0);
    push(3, ADJ_HOLD, 0);
    push(3, ADJ_HOLD, 0);
    restart(3, 5);
    wait_drain("mult3_hold", 2500);

    // Switch to 6 edges/period at the next boundary: 1 period at e=0,
    // 7 periods at e=+3 -> +21.
    pat_next = 6;
    push(3, ADJ_DOWN, 21);
    wait_drain("mult3_burst", 1000);

    @(posedge clk);
    en3 = 1'b0;
    repeat (50) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_freq_comparator.md
# pll_freq_comparator

- Synthesizable, parametrised frequency comparator for the N× PLL VFO control loop.
- Samples the reference clock and the PLL output as data on a single fast system clock.
- Counts PLL rising edges per reference period and accumulates the signed error against the multiplier over 2^AVG_LOG2 periods.
- Issues the standard 2-bit AdjustFreq code, a decision strobe and an optional lock indication; sits between the reference input and the VFO frequency-control port.

## Interface
- MULT, 1: expected PLL rising edges per reference period (1..2^CNT_W−1).
- CNT_W, 4: PLL edge counter width; count saturates at 2^CNT_W−1.
- AVG_LOG2, 3: averaging window of 2^AVG_LOG2 reference periods (≥1).
- THRESH, 1: dead-band half-width on the accumulated error (≥0).
- LOCK_CNT, 4: consecutive in-band decisions required to assert Locked (≥1).
- ClockIn  input  1  system sampling clock; must be ≥4× the faster of RefIn and PllIn.
- ResetN  input  1  reset, asynchronous, active-low.
- Enable  input  1  comparator run enable.
- RefIn  input  1  reference clock, asynchronous, sampled as data.
- PllIn  input  1  PLL/VFO output, asynchronous, sampled as data.
- AdjustFreq  output  2  2'b11 speed up, 2'b00 slow down, 2'b01 no change.
- DecisionValid  output  1  one-cycle pulse when AdjustFreq is updated.
- AvgError  output  CNT_W+AVG_LOG2+1  signed accumulated error of the last decision window.
- Locked  output  1  lock indication.

## Operation
- RefIn and PllIn each pass through a 2-FF synchronizer followed by a rising-edge detector, producing RefEdge and PllEdge pulses.
- Armed flag: cleared by reset and while Enable=0. The first RefEdge with Enable=1 sets Armed, clears PllCount, and produces no error. This discards the partial first period.
- While Armed, each PllEdge increments PllCount, saturating at 2^CNT_W−1.
- On each RefEdge while Armed:
  - e = PllCount − MULT, signed, CNT_W+1 bits.
  - Acc += e. Acc is signed, CNT_W+AVG_LOG2+1 bits, and cannot overflow.
  - PllCount restarts at 0, or at 1 if PllEdge occurs in the same cycle.
  - Period counter Per increments and wraps at 2^AVG_LOG2.
- Simultaneous PllEdge and RefEdge: the PLL edge belongs to the new period.
- When Per wraps to 0, the decision is taken on the final Acc (including the last e):
  - Acc < −THRESH → AdjustFreq=2'b11.
  - Acc > THRESH → AdjustFreq=2'b00.
  - Otherwise AdjustFreq=2'b01.
  - AvgError is loaded with the final Acc, DecisionValid pulses, and Acc clears to 0.
- Enable deassertion clears Armed, Acc, Per and PllCount, and forces AdjustFreq=2'b01 and Locked=0. AvgError holds its last value.
- States: IDLE (Enable=0), ARMING (waiting for first RefEdge), RUN.
  - IDLE→ARMING on Enable=1.
  - ARMING→RUN on RefEdge.
  - Any state→IDLE on Enable=0.

## Timing
- Reset values: AdjustFreq=2'b01, DecisionValid=0, AvgError=0, Locked=0. All internal counters are 0 and the state is IDLE.
- Pin to edge pulse: 3 ClockIn cycles (2 synchronizer stages + edge register).
- Decision latency: AdjustFreq, AvgError and DecisionValid are registered 1 cycle after the RefEdge pulse that closes the window.
- AdjustFreq holds its value between DecisionValid pulses.
- Asserting reset mid-window discards all partial state immediately; no decision is issued.

## Configuration
- PLLCMP_LOCK_DET_EN defined:
  - A lock counter increments on each 2'b01 decision, saturating at LOCK_CNT.
  - It clears on any 2'b11 or 2'b00 decision.
  - Locked=1 while the counter equals LOCK_CNT; Locked updates in the same cycle as DecisionValid.
- PLLCMP_LOCK_DET_EN undefined: no lock counter is built, and Locked is tied to 0.

## Structure
- Package pll_cmp_pkg holds:
  - ADJ_UP=2'b11, ADJ_DOWN=2'b00, ADJ_HOLD=2'b01.
  - The state encoding for IDLE/ARMING/RUN.
- Sub-module edge_sync contains the 2-FF synchronizer and the rising-edge pulse generator. It is instantiated twice, for RefIn and PllIn.

## Test plan
Defaults throughout; ClockIn period 10 ns; RefIn period 320 ns.
- PllIn = RefIn frequency, MULT=1 → e=0 every period, AvgError=0, AdjustFreq=2'b01 at each DecisionValid (every 8 ref periods).
- PllIn period 640 ns → Acc=−4 → AdjustFreq=2'b11, AvgError=−4.
- PllIn period 160 ns → Acc=+8 → AdjustFreq=2'b00.
- MULT=3, PllIn period 107 ns (≈3×) → AdjustFreq=2'b01. With PLLCMP_LOCK_DET_EN, Locked=1 after the 4th DecisionValid; a subsequent 2×-rate burst gives 2'b00 and Locked=0.
- PLL edge forced coincident with the RefEdge sample → counted in the new period; window sum unchanged versus a 1-cycle-offset edge.
- ResetN pulsed low at ref period 5 of a window → outputs at reset values immediately; the next DecisionValid occurs 9 ref edges after release (1 arming + 8).
